// File: rtl/ni_port_ctrl_if.sv
// Bundle of the core-side and router-side signals of one NoC port controller.
// The slave modport is the controller's view; master is the core/router view.
interface ni_port_ctrl_if #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 32
);
    localparam int FW = DATA_W + 2 * ADDR_W;

    logic              proc_valid;
    logic [ADDR_W-1:0] proc_dest;
    logic [DATA_W-1:0] proc_data;
    logic              stall;
    logic              proc_ready_in;
    logic              proc_rx_valid;
    logic [DATA_W-1:0] proc_rx_data;
    logic [ADDR_W-1:0] proc_rx_src;
    logic              tx_valid;
    logic              tx_ready;
    logic [FW-1:0]     tx_flit;
    logic              net_rx_valid;
    logic              net_rx_ready;
    logic [FW-1:0]     net_rx_flit;
    logic              tx_timeout;
    logic              rx_misroute;

    modport slave (
        input  proc_valid, proc_dest, proc_data, proc_ready_in,
        input  tx_ready, net_rx_valid, net_rx_flit,
        output stall, proc_rx_valid, proc_rx_data, proc_rx_src,
        output tx_valid, tx_flit, net_rx_ready, tx_timeout, rx_misroute
    );

    modport master (
        output proc_valid, proc_dest, proc_data, proc_ready_in,
        output tx_ready, net_rx_valid, net_rx_flit,
        input  stall, proc_rx_valid, proc_rx_data, proc_rx_src,
        input  tx_valid, tx_flit, net_rx_ready, tx_timeout, rx_misroute
    );
endinterface

// File: rtl/ni_port_ctrl.sv
// NoC port controller: one-deep send buffer with valid/ready injection and a
// 2-entry receive FIFO toward the core, plus sticky timeout/misroute flags.
module ni_port_ctrl #(
    parameter int NODE_ID = 0,
    parameter int ADDR_W  = 2,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input logic            clk,
    input logic            rst,
    ni_port_ctrl_if.slave  bus
);
    localparam int FW      = DATA_W + 2 * ADDR_W;
    localparam int ENTRY_W = ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] NODE   = ADDR_W'(NODE_ID);
    localparam logic [CNT_W-1:0]  TO_MAX = CNT_W'(TIMEOUT);

    typedef enum logic {IDLE, SEND} tx_state_t;

    tx_state_t         state_reg, state_next;
    logic [FW-1:0]     flit_reg, flit_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              timeout_reg, timeout_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            flit_reg    <= '0;
            cnt_reg     <= '0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            flit_reg    <= flit_next;
            cnt_reg     <= cnt_next;
            timeout_reg <= timeout_next;
        end
    end

    always_comb begin
        logic capture;
        state_next   = state_reg;
        flit_next    = flit_reg;
        cnt_next     = cnt_reg;
        timeout_next = timeout_reg;
        capture      = 1'b0;
        case (state_reg)
            IDLE: capture = bus.proc_valid;
            SEND: begin
                if (bus.tx_ready) begin
                    if (bus.proc_valid) capture = 1'b1;
                    else                state_next = IDLE;
                end else if (cnt_reg != TO_MAX) begin
                    // Wait count saturates; the flit keeps being offered regardless.
                    cnt_next = cnt_reg + 1'b1;
                    if (cnt_next == TO_MAX) timeout_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        if (capture) begin
            state_next = SEND;
            flit_next  = {NODE, bus.proc_dest, bus.proc_data};
            cnt_next   = '0;
        end
    end

    assign bus.tx_valid   = (state_reg == SEND);
    assign bus.tx_flit    = flit_reg;
    assign bus.tx_timeout = timeout_reg;
    assign bus.stall      = (state_reg == SEND) & bus.proc_valid & ~bus.tx_ready;

    // Receive side
    logic                     wr_ptr_reg, rd_ptr_reg;
    logic [1:0]               count_reg;
    logic                     misroute_reg;
    logic [1:0][ENTRY_W-1:0]  entries;
    logic [ADDR_W-1:0]        rx_src, rx_dest;
    logic [DATA_W-1:0]        rx_data;
    logic                     rx_ready, accept, store, pop;

    assign rx_src   = bus.net_rx_flit[FW-1 -: ADDR_W];
    assign rx_dest  = bus.net_rx_flit[DATA_W +: ADDR_W];
    assign rx_data  = bus.net_rx_flit[DATA_W-1:0];
    assign rx_ready = (count_reg != 2'd2);
    assign accept   = bus.net_rx_valid & rx_ready;
    assign store    = accept & (rx_dest == NODE);
    assign pop      = (count_reg != 2'd0) & bus.proc_ready_in;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            logic [ENTRY_W-1:0] entry_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    entry_reg <= '0;
                else if (store && wr_ptr_reg == 1'(gi))
                    entry_reg <= {rx_src, rx_data};
            end
            assign entries[gi] = entry_reg;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg   <= 1'b0;
            rd_ptr_reg   <= 1'b0;
            count_reg    <= 2'd0;
            misroute_reg <= 1'b0;
        end else begin
            if (store) wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)   rd_ptr_reg <= ~rd_ptr_reg;
            case ({store, pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
            // Misrouted flits are drained so they cannot block the router port.
            if (accept && !store) misroute_reg <= 1'b1;
        end
    end

    assign bus.net_rx_ready  = rx_ready;
    assign bus.proc_rx_valid = (count_reg != 2'd0);
    assign {bus.proc_rx_src, bus.proc_rx_data} = entries[rd_ptr_reg];
    assign bus.rx_misroute   = misroute_reg;
endmodule

// File: tb/tb_ni_port_ctrl.sv
// Scoreboard bench for ni_port_ctrl: a driver runs a transaction-level model and
// queues expected flits/words; a negedge monitor compares them at each handshake.
module tb_ni_port_ctrl;
    localparam int NODE_ID = 1;
    localparam int ADDR_W  = 2;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 4;
    localparam int FW      = DATA_W + 2 * ADDR_W;
    localparam logic [ADDR_W-1:0] ME = ADDR_W'(NODE_ID);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ni_port_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ni_port_ctrl #(
        .NODE_ID(NODE_ID), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int tests = 0;
    int fails = 0;

    logic [FW-1:0]            tx_exp_q[$];
    logic [ADDR_W+DATA_W-1:0] rx_exp_q[$];

    // Transaction-level model state
    bit m_pending;
    int m_wait;
    bit m_timeout;
    bit m_misroute;
    int m_rx_cnt;
    bit last_stall;
    bit last_refused;

    // Held random stimulus
    bit                r_pv, r_trdy, r_nv, r_prdy;
    logic [ADDR_W-1:0] r_pd;
    logic [DATA_W-1:0] r_pdat;
    logic [FW-1:0]     r_nf;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [FW-1:0] mk(input logic [ADDR_W-1:0] src,
                                         input logic [ADDR_W-1:0] dest,
                                         input logic [DATA_W-1:0] data);
        return {src, dest, data};
    endfunction

    task automatic model_reset();
        m_pending = 0; m_wait = 0; m_timeout = 0; m_misroute = 0; m_rx_cnt = 0;
        last_stall = 0; last_refused = 0;
        tx_exp_q.delete();
        rx_exp_q.delete();
    endtask

    // One clock cycle: drive inputs, check registered/combinational outputs
    // against the model, then advance the model across the coming edge.
    task automatic step(input bit pv, input logic [ADDR_W-1:0] pd, input logic [DATA_W-1:0] pdat,
                        input bit trdy, input bit nv, input logic [FW-1:0] nf, input bit prdy);
        bit exp_stall, taken, acc, store, pop;
        @(posedge clk);
        #1;
        bus.proc_valid    = pv;
        bus.proc_dest     = pd;
        bus.proc_data     = pdat;
        bus.tx_ready      = trdy;
        bus.net_rx_valid  = nv;
        bus.net_rx_flit   = nf;
        bus.proc_ready_in = prdy;
        #4;
        exp_stall = m_pending && pv && !trdy;
        check("stall",         bus.stall,         exp_stall);
        check("tx_valid",      bus.tx_valid,      m_pending);
        check("tx_timeout",    bus.tx_timeout,    m_timeout);
        check("rx_misroute",   bus.rx_misroute,   m_misroute);
        check("net_rx_ready",  bus.net_rx_ready,  m_rx_cnt < 2);
        check("proc_rx_valid", bus.proc_rx_valid, m_rx_cnt != 0);

        taken = pv && !exp_stall;
        if (taken) begin
            tx_exp_q.push_back(mk(ME, pd, pdat));
            m_wait = 0;
        end else if (m_pending && !trdy) begin
            if (m_wait < TIMEOUT) m_wait++;
            if (m_wait == TIMEOUT) m_timeout = 1;
        end
        if (taken)                m_pending = 1;
        else if (m_pending && trdy) m_pending = 0;

        acc   = nv && (m_rx_cnt < 2);
        store = acc && (nf[DATA_W +: ADDR_W] == ME);
        if (acc && !store) m_misroute = 1;
        if (store) rx_exp_q.push_back({nf[FW-1 -: ADDR_W], nf[DATA_W-1:0]});
        pop = (m_rx_cnt != 0) && prdy;
        m_rx_cnt = m_rx_cnt + int'(store) - int'(pop);

        last_stall   = exp_stall;
        last_refused = nv && !acc;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, '0, 1, 0, '0, 1);
    endtask

    // Monitor: handshakes complete on the next rising edge, inputs are stable here.
    always @(negedge clk) begin
        logic [FW-1:0]            et;
        logic [ADDR_W+DATA_W-1:0] er;
        if (!rst) begin
            if (bus.tx_valid && bus.tx_ready) begin
                check("tx_expected_avail", tx_exp_q.size() > 0, 1'b1);
                if (tx_exp_q.size() > 0) begin
                    et = tx_exp_q.pop_front();
                    check("tx_flit", bus.tx_flit, et);
                    $display("[TB] tx flit %h expected %h", bus.tx_flit, et);
                end
            end
            if (bus.proc_rx_valid && bus.proc_ready_in) begin
                check("rx_expected_avail", rx_exp_q.size() > 0, 1'b1);
                if (rx_exp_q.size() > 0) begin
                    er = rx_exp_q.pop_front();
                    check("rx_word", {bus.proc_rx_src, bus.proc_rx_data}, er);
                    $display("[TB] rx src %0d data %h expected src %0d data %h",
                             bus.proc_rx_src, bus.proc_rx_data,
                             er[ADDR_W+DATA_W-1 -: ADDR_W], er[DATA_W-1:0]);
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_valid"},      bus.tx_valid,      1'b0);
        check({tag, "_tx_flit"},       bus.tx_flit,       '0);
        check({tag, "_stall"},         bus.stall,         1'b0);
        check({tag, "_proc_rx_valid"}, bus.proc_rx_valid, 1'b0);
        check({tag, "_proc_rx_data"},  bus.proc_rx_data,  '0);
        check({tag, "_proc_rx_src"},   bus.proc_rx_src,   '0);
        check({tag, "_net_rx_ready"},  bus.net_rx_ready,  1'b1);
        check({tag, "_tx_timeout"},    bus.tx_timeout,    1'b0);
        check({tag, "_rx_misroute"},   bus.rx_misroute,   1'b0);
    endtask

    initial begin
        rst = 1'b1;
        bus.proc_valid = 0; bus.proc_dest = '0; bus.proc_data = '0;
        bus.tx_ready = 0; bus.net_rx_valid = 0; bus.net_rx_flit = '0;
        bus.proc_ready_in = 0;
        model_reset();
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Single send to node 2: flit 0x6DEADBEEF, one cycle of tx_valid
        step(1, 2'd2, 32'hDEADBEEF, 1, 0, '0, 0);
        idle(3);

        // RX full: three flits with core not accepting, then drain in order
        step(0, '0, '0, 1, 1, mk(2'd2, ME, 32'hAAAA0001), 0);
        step(0, '0, '0, 1, 1, mk(2'd3, ME, 32'hAAAA0002), 0);
        step(0, '0, '0, 1, 1, mk(2'd0, ME, 32'hAAAA0003), 0);
        step(0, '0, '0, 1, 1, mk(2'd0, ME, 32'hAAAA0003), 1);
        step(0, '0, '0, 1, 1, mk(2'd0, ME, 32'hAAAA0003), 1);
        idle(2);

        // Misroute, then push and pop together at count 1
        step(0, '0, '0, 1, 1, mk(2'd2, 2'd3, 32'hBAD0BAD0), 0);
        step(0, '0, '0, 1, 1, mk(2'd3, ME, 32'h11111111), 0);
        step(0, '0, '0, 1, 1, mk(2'd2, ME, 32'h22222222), 1);
        idle(3);

        // Backpressure: second send stalls until tx_ready; timeout trips
        step(1, 2'd3, 32'h0000A0A0, 0, 0, '0, 1);
        for (int i = 0; i < 6; i++) step(1, 2'd0, 32'h0000B0B0, 0, 0, '0, 1);
        step(1, 2'd0, 32'h0000B0B0, 1, 0, '0, 1);
        idle(3);

        // Randomized traffic; stalled sends and refused flits are held
        for (int i = 0; i < 600; i++) begin
            if (!last_stall) begin
                r_pv   = ($urandom_range(0, 1) == 1);
                r_pd   = ADDR_W'($urandom);
                r_pdat = $urandom;
            end
            r_trdy = ($urandom_range(0, 3) != 0);
            if (!last_refused) begin
                r_nv = ($urandom_range(0, 1) == 1);
                r_nf = mk(ADDR_W'($urandom),
                          ($urandom_range(0, 4) == 0) ? ADDR_W'($urandom) : ME,
                          $urandom);
            end
            r_prdy = ($urandom_range(0, 2) != 0);
            step(r_pv, r_pd, r_pdat, r_trdy, r_nv, r_nf, r_prdy);
        end
        if (last_stall) step(r_pv, r_pd, r_pdat, 1, 0, '0, 1);
        idle(8);
        #1;
        check("tx_queue_drained", tx_exp_q.size(), 0);
        check("rx_queue_drained", rx_exp_q.size(), 0);

        // Async reset while a send is pending and the FIFO is full
        step(1, 2'd2, 32'hCAFE0001, 0, 1, mk(2'd2, ME, 32'hC0C0C0C1), 0);
        step(0, '0, '0, 0, 1, mk(2'd3, ME, 32'hC0C0C0C2), 0);
        step(1, 2'd1, 32'hCAFE0002, 0, 0, '0, 0);
        check("pre_reset_fifo_full", bus.net_rx_ready, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        model_reset();
        bus.proc_valid = 0; bus.net_rx_valid = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ni_port_ctrl.md
# ni_port_ctrl

Network-interface port controller placed between the pipelined MIPS core's NoC signals and one router local port. It buffers one outgoing execute-stage send, injects it as a flit with valid/ready handshaking, and stalls the pipeline only when a second send arrives while the first is pending. Received flits go into a 2-entry FIFO and are handed to the core under proc_ready_in. Sticky error flags report injection timeouts and misrouted flits.

## Interface
- NODE_ID, 0: this node's address, ADDR_W bits
- ADDR_W, 2: node address width
- DATA_W, 32: payload width
- TIMEOUT, 64: SEND-state cycles without tx_ready before tx_timeout sets (≥1)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- proc_valid  in  1  core presents a send this cycle (execute stage)
- proc_dest  in  ADDR_W  destination node of the send
- proc_data  in  DATA_W  payload of the send
- stall  out  1  freeze pipeline; send not taken this cycle
- proc_ready_in  in  1  core accepts a received word this cycle
- proc_rx_valid  out  1  received word available
- proc_rx_data  out  DATA_W  received payload (FIFO head)
- proc_rx_src  out  ADDR_W  source node of FIFO head
- tx_valid  out  1  flit offered to router
- tx_ready  in  1  router accepts flit
- tx_flit  out  DATA_W+2*ADDR_W  {src, dest, data}
- net_rx_valid  in  1  router offers flit
- net_rx_ready  out  1  controller can accept flit
- net_rx_flit  in  DATA_W+2*ADDR_W  {src, dest, data}
- tx_timeout  out  1  sticky: injection exceeded TIMEOUT
- rx_misroute  out  1  sticky: flit with dest ≠ NODE_ID received

## Operation
- Flit: [FW-1 -: ADDR_W]=src, [DATA_W+ADDR_W-1:DATA_W]=dest, [DATA_W-1:0]=data, where FW = DATA_W+2*ADDR_W.
- TX FSM: IDLE, SEND.
  - IDLE: proc_valid=1 → tx_flit <= {NODE_ID, proc_dest, proc_data}; go to SEND; clear the timeout counter.
  - SEND: tx_valid=1 and tx_flit is held stable.
    - tx_ready=1 with proc_valid=1: capture the new send; stay in SEND; clear the counter.
    - tx_ready=1 with proc_valid=0: go to IDLE.
    - tx_ready=0: the counter increments, saturating at TIMEOUT. On reaching TIMEOUT, tx_timeout <= 1. The flit is still offered; it is never dropped.
- stall = (state==SEND) & proc_valid & ~tx_ready. Combinational. Never asserted in IDLE.
- A send with proc_dest==NODE_ID is injected normally, with no special case.
- RX FIFO: 2 entries, each holding {src, data}. Pointers wrap modulo 2; count runs 0..2.
  - net_rx_ready = (count<2). Derived from registered count only; no combinational path from proc_ready_in.
  - Push on net_rx_valid & net_rx_ready. A flit with dest ≠ NODE_ID is consumed but not stored, and rx_misroute <= 1.
  - proc_rx_valid = (count≠0). proc_rx_data/src show the head entry.
  - Pop on proc_rx_valid & proc_ready_in.
  - Simultaneous push and pop: count unchanged. This can occur only at count=1 (count=0: no pop; count=2: no push).
- Sticky flags clear only on rst.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE, tx_valid=0, tx_flit=0, counter=0, FIFO empty, storage=0.
  - Outputs: proc_rx_valid=0, proc_rx_data=0, proc_rx_src=0, net_rx_ready=1, stall=0, both flags 0.
- Reset during SEND drops the pending flit. tx_valid falls with rst assertion.
- Send latency: proc_valid in cycle N → tx_valid in cycle N+1. A flit accepted on tx_ready=1 in cycle M is replaced by the next flit in M+1, or tx_valid=0.
- Back-to-back throughput: one flit per cycle while tx_ready=1.
- RX latency: flit pushed in cycle N → proc_rx_valid in N+1. No bypass.
- tx_timeout rises on the edge where the count of consecutive SEND cycles with tx_ready=0 reaches TIMEOUT.

## Test plan
- Single send: NODE_ID=1, proc_valid for 1 cycle with dest=2, data=0xDEADBEEF, tx_ready=1 → tx_valid high exactly 1 cycle, tx_flit=0x6DEADBEEF, stall never high.
- Backpressure: tx_ready=0, two sends in consecutive cycles → first held in tx_flit, stall=1 on the second until tx_ready=1. Then the second is captured, and the flits appear in order.
- Timeout: TIMEOUT=4, hold tx_ready=0 → tx_timeout=1 after the 4th SEND cycle and stays 1 after delivery. The flit is still delivered when tx_ready=1.
- RX full: proc_ready_in=0, three flits offered to NODE_ID → net_rx_ready=0 after 2 pushes. Then proc_ready_in=1 → data popped in arrival order with correct src; the third flit is accepted once count<2.
- Misroute plus simultaneous push/pop: flit with dest≠NODE_ID → rx_misroute=1, count unchanged. At count=1, push and pop in the same cycle → count stays 1.
- Async reset mid-SEND with FIFO count=2 → all outputs return to their reset values without waiting for a clock edge.
